// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller: one-hot arbiter state
// encodings, SDRAM command codes {cs_n,ras_n,cas_n,we_n} and bus widths.
package sdram_pkg;

  localparam int ADDR_W = 12;
  localparam int BANK_W = 2;
  localparam int CMD_W  = 4;

  // One-hot arbiter state. 6'b00_0100 is reserved and never driven.
  typedef enum logic [5:0] {
    INIT  = 6'b00_0001,
    ARBIT = 6'b00_0010,
    WRITE = 6'b00_1000,
    READ  = 6'b01_0000,
    AREF  = 6'b10_0000
  } state_t;

  localparam logic [CMD_W-1:0] NOP      = 4'b0111;
  localparam logic [CMD_W-1:0] PRE      = 4'b0010;
  localparam logic [CMD_W-1:0] ACT      = 4'b0011;
  localparam logic [CMD_W-1:0] RD       = 4'b0101;
  localparam logic [CMD_W-1:0] WR       = 4'b0100;
  localparam logic [CMD_W-1:0] AREF_CMD = 4'b0001;
  localparam logic [CMD_W-1:0] MRS      = 4'b0000;

endpackage

// File: rtl/sdram_ref_timer.sv
// Periodic auto-refresh request generator.
// Ports:
//   clk, rst        clock, async active-high reset
//   en_i            count enable (arbiter has left INIT); timer held at 0 otherwise
//   ref_en_i        refresh grant; clears the pending request
//   ref_req_o       pending refresh request
//   ref_overrun_o   sticky: a period expired while a request was still pending
module sdram_ref_timer #(
  parameter int REF_PERIOD = 780
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic ref_en_i,
  output logic ref_req_o,
  output logic ref_overrun_o
);
  localparam int CNT_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REF_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ref_req_q, ovr_q;
  logic             expire;

  assign expire = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en_i || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      ref_req_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      // Set beats clear when the period expires on the grant cycle.
      if (expire)        ref_req_q <= 1'b1;
      else if (ref_en_i) ref_req_q <= 1'b0;
      if (expire && ref_req_q) ovr_q <= 1'b1;
    end
  end

  assign ref_req_o     = ref_req_q;
  assign ref_overrun_o = ovr_q;

endmodule

// File: rtl/sdram_arbit.sv
// Central arbiter and command multiplexer for the SDRAM controller.
// Owns the one-hot state bus, issues one-cycle grants to the refresh, write
// and read engines (fixed priority refresh > write > read, bursts never
// pre-empted), generates the periodic refresh request and registers the
// active engine's cmd/addr/bank onto the SDRAM bus (1-cycle latency).
// Ports:
//   clk, rst                         clock, async active-high reset
//   flag_init_end, init_cmd/addr     init engine
//   flag_ref_end, ref_cmd/addr       refresh engine
//   wr_req, flag_wr_end, wr_*        write engine
//   rd_req, flag_rd_end, rd_*        read engine
//   state, ref_req                   fed back to all engines
//   ref_en, wr_en, rd_en             one-cycle grants
//   ref_overrun                      sticky refresh overrun
//   sdram_cmd/addr/bank              muxed SDRAM bus
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int REF_PERIOD = 780
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flag_init_end,
  input  logic [CMD_W-1:0]  init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              flag_ref_end,
  input  logic [CMD_W-1:0]  ref_cmd,
  input  logic [ADDR_W-1:0] ref_addr,
  input  logic              wr_req,
  input  logic              flag_wr_end,
  input  logic [CMD_W-1:0]  wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic              rd_req,
  input  logic              flag_rd_end,
  input  logic [CMD_W-1:0]  rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BANK_W-1:0] rd_bank,
  output logic [5:0]        state,
  output logic              ref_req,
  output logic              ref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              ref_overrun,
  output logic [CMD_W-1:0]  sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BANK_W-1:0] sdram_bank
);

  state_t              state_q;
  logic                ref_en_q, wr_en_q, rd_en_q;
  logic [CMD_W-1:0]    cmd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [BANK_W-1:0]   bank_q;

  sdram_ref_timer #(.REF_PERIOD(REF_PERIOD)) u_ref_timer (
    .clk          (clk),
    .rst          (rst),
    .en_i         (state_q != INIT),
    .ref_en_i     (ref_en_q),
    .ref_req_o    (ref_req),
    .ref_overrun_o(ref_overrun)
  );

  // Grants are asserted on the same edge the state enters the burst, so they
  // are naturally single-cycle and mutually exclusive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= INIT;
      ref_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
    end else begin
      ref_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      case (state_q)
        INIT:  if (flag_init_end) state_q <= ARBIT;
        ARBIT: begin
          if (ref_req) begin
            state_q  <= AREF;
            ref_en_q <= 1'b1;
          end else if (wr_req) begin
            state_q <= WRITE;
            wr_en_q <= 1'b1;
          end else if (rd_req) begin
            state_q <= READ;
            rd_en_q <= 1'b1;
          end
        end
        AREF:    if (flag_ref_end) state_q <= ARBIT;
        WRITE:   if (flag_wr_end)  state_q <= ARBIT;
        READ:    if (flag_rd_end)  state_q <= ARBIT;
        default: state_q <= ARBIT;
      endcase
    end
  end

  // Bus mux keys off the registered state; in ARBIT the bus idles with NOP
  // but address/bank hold so the pins do not toggle needlessly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q  <= NOP;
      addr_q <= '0;
      bank_q <= '0;
    end else begin
      case (state_q)
        INIT: begin
          cmd_q  <= init_cmd;
          addr_q <= init_addr;
          bank_q <= '0;
        end
        AREF: begin
          cmd_q  <= ref_cmd;
          addr_q <= ref_addr;
          bank_q <= '0;
        end
        WRITE: begin
          cmd_q  <= wr_cmd;
          addr_q <= wr_addr;
          bank_q <= wr_bank;
        end
        READ: begin
          cmd_q  <= rd_cmd;
          addr_q <= rd_addr;
          bank_q <= rd_bank;
        end
        default: cmd_q <= NOP;
      endcase
    end
  end

  assign state      = state_q;
  assign ref_en     = ref_en_q;
  assign wr_en      = wr_en_q;
  assign rd_en      = rd_en_q;
  assign sdram_cmd  = cmd_q;
  assign sdram_addr = addr_q;
  assign sdram_bank = bank_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// Scoreboard bench for sdram_arbit: the stimulus pushes each expected
// state transition (state + grant vector) before causing it; a negedge
// monitor pops and compares on every state change or grant. Bus mux, timer
// and overrun behaviour are checked directly at hand-computed cycles.
module tb_sdram_arbit;

  localparam logic [5:0] S_INIT  = 6'b00_0001;
  localparam logic [5:0] S_ARBIT = 6'b00_0010;
  localparam logic [5:0] S_WRITE = 6'b00_1000;
  localparam logic [5:0] S_READ  = 6'b01_0000;
  localparam logic [5:0] S_AREF  = 6'b10_0000;
  localparam logic [3:0] C_NOP = 4'b0111, C_PRE = 4'b0010, C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101, C_WR  = 4'b0100, C_REF = 4'b0001;
  localparam int P = 780;

  typedef struct packed {
    logic [5:0] st;
    logic [2:0] g;   // {ref_en, wr_en, rd_en}
  } ev_t;

  logic clk = 1'b0, rst = 1'b1;
  logic flag_init_end = 0, flag_ref_end = 0, flag_wr_end = 0, flag_rd_end = 0;
  logic wr_req = 0, rd_req = 0;
  logic [3:0]  init_cmd = C_PRE, ref_cmd = C_REF, wr_cmd = C_WR, rd_cmd = C_RD;
  logic [11:0] init_addr = 12'h400, ref_addr = 12'h0AA, wr_addr = 12'h123, rd_addr = 12'h3C3;
  logic [1:0]  wr_bank = 2'd2, rd_bank = 2'd1;
  logic [5:0]  state;
  logic        ref_req, ref_en, wr_en, rd_en, ref_overrun;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_bank;

  int checks = 0, failures = 0;
  ev_t exp_q[$];
  logic mon_on = 1'b0;
  logic [5:0] prev_st;

  sdram_arbit dut (
    .clk(clk), .rst(rst),
    .flag_init_end(flag_init_end), .init_cmd(init_cmd), .init_addr(init_addr),
    .flag_ref_end(flag_ref_end), .ref_cmd(ref_cmd), .ref_addr(ref_addr),
    .wr_req(wr_req), .flag_wr_end(flag_wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
    .rd_req(rd_req), .flag_rd_end(flag_rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .state(state), .ref_req(ref_req), .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en),
    .ref_overrun(ref_overrun), .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 2 time units after the active edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [5:0] st, input logic [2:0] g);
    ev_t e;
    e.st = st;
    e.g  = g;
    exp_q.push_back(e);
  endtask

  task automatic wait_ref_req(input string name, input int limit);
    int n;
    n = 0;
    while (!ref_req && n < limit) begin
      step();
      n++;
    end
    chk(name, {31'd0, ref_req}, 32'd1);
  endtask

  // Monitor: every state change or grant must match the scoreboard head.
  always @(negedge clk) begin
    if (mon_on) begin
      if (state !== prev_st || {ref_en, wr_en, rd_en} !== 3'b000) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event: state=%b grants=%b", state, {ref_en, wr_en, rd_en});
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("event_state_grants", {23'd0, state, ref_en, wr_en, rd_en}, {23'd0, e});
        end
      end
      prev_st = state;
    end
  end

  initial begin
    // ---- reset state
    repeat (3) step();
    chk("rst_state", {26'd0, state}, {26'd0, S_INIT});
    chk("rst_grants", {28'd0, ref_req, ref_en, wr_en, rd_en}, 32'd0);
    chk("rst_overrun", {31'd0, ref_overrun}, 32'd0);
    chk("rst_bus", {14'd0, sdram_cmd, sdram_addr, sdram_bank}, {14'd0, C_NOP, 12'd0, 2'd0});
    prev_st = S_INIT;
    mon_on  = 1'b1;
    rst     = 1'b0;
    step();
    chk("init_mux", {14'd0, sdram_cmd, sdram_addr, sdram_bank}, {14'd0, C_PRE, 12'h400, 2'd0});
    repeat (8) step();

    // ---- init done at cycle 10 -> ARBIT at 11
    push(S_ARBIT, 3'b000);
    flag_init_end = 1'b1;
    step();                                        // edge t0: ARBIT
    chk("arbit_entered", {26'd0, state}, {26'd0, S_ARBIT});
    step();                                        // t0+1
    chk("arbit_nop_hold", {14'd0, sdram_cmd, sdram_addr, sdram_bank}, {14'd0, C_NOP, 12'h400, 2'd0});
    repeat (P - 2) step();                         // t0+779
    chk("ref_req_before", {31'd0, ref_req}, 32'd0);
    push(S_AREF, 3'b100);
    step();                                        // t0+780
    chk("ref_req_rise", {31'd0, ref_req}, 32'd1);
    step();                                        // t0+781: AREF, ref_en
    chk("ref_req_on_grant", {31'd0, ref_req}, 32'd1);
    step();                                        // t0+782
    chk("ref_req_cleared", {30'd0, ref_req, ref_en}, 32'd0);
    chk("aref_mux", {14'd0, sdram_cmd, sdram_addr, sdram_bank}, {14'd0, C_REF, 12'h0AA, 2'd0});
    push(S_ARBIT, 3'b000);
    flag_ref_end = 1'b1;
    step();
    flag_ref_end = 1'b0;

    // ---- write beats read; one ARBIT cycle between bursts
    push(S_WRITE, 3'b010);
    wr_req = 1'b1;
    rd_req = 1'b1;
    step();
    wr_req = 1'b0;
    step();
    chk("write_mux", {14'd0, sdram_cmd, sdram_addr, sdram_bank}, {14'd0, C_WR, 12'h123, 2'd2});
    push(S_ARBIT, 3'b000);
    push(S_READ, 3'b001);
    flag_wr_end = 1'b1;
    step();
    flag_wr_end = 1'b0;
    step();                                        // READ, rd_en
    // Done flags of other engines must be ignored in READ.
    flag_wr_end  = 1'b1;
    flag_ref_end = 1'b1;
    step();
    flag_wr_end  = 1'b0;
    flag_ref_end = 1'b0;
    chk("foreign_flag_ignored", {26'd0, state}, {26'd0, S_READ});
    chk("read_mux", {14'd0, sdram_cmd, sdram_addr, sdram_bank}, {14'd0, C_RD, 12'h3C3, 2'd1});
    rd_cmd = C_ACT;
    #1;
    chk("read_mux_latency", {28'd0, sdram_cmd}, {28'd0, C_RD});
    step();
    chk("read_mux_track", {28'd0, sdram_cmd}, {28'd0, C_ACT});

    // ---- refresh pending mid-READ: no pre-emption, then refresh beats rd_req
    wait_ref_req("ref_req_mid_read", 1000);
    repeat (3) step();
    chk("read_not_preempted", {26'd0, state}, {26'd0, S_READ});
    push(S_ARBIT, 3'b000);
    push(S_AREF, 3'b100);
    flag_rd_end = 1'b1;
    step();
    flag_rd_end = 1'b0;
    step();                                        // AREF
    step();
    chk("aref2_mux_bank0", {14'd0, sdram_cmd, sdram_addr, sdram_bank}, {14'd0, C_REF, 12'h0AA, 2'd0});

    // ---- hold refresh so a pending request survives a full period
    wait_ref_req("ref_req_in_aref", 800);
    chk("no_overrun_yet", {31'd0, ref_overrun}, 32'd0);
    repeat (P - 1) step();
    chk("overrun_before", {31'd0, ref_overrun}, 32'd0);
    step();
    chk("overrun_set", {31'd0, ref_overrun}, 32'd1);
    push(S_ARBIT, 3'b000);
    push(S_AREF, 3'b100);
    flag_ref_end = 1'b1;
    step();
    flag_ref_end = 1'b0;
    step();                                        // AREF again (pending refresh)
    push(S_ARBIT, 3'b000);
    push(S_READ, 3'b001);
    flag_ref_end = 1'b1;
    step();
    flag_ref_end = 1'b0;
    step();                                        // READ
    rd_req = 1'b0;
    chk("overrun_sticky", {31'd0, ref_overrun}, 32'd1);
    push(S_ARBIT, 3'b000);
    flag_rd_end = 1'b1;
    step();
    flag_rd_end = 1'b0;

    // ---- reset during WRITE
    push(S_WRITE, 3'b010);
    wr_req = 1'b1;
    step();
    step();
    push(S_INIT, 3'b000);
    rst           = 1'b1;
    flag_init_end = 1'b0;
    #1;
    chk("rst_mid_state", {26'd0, state}, {26'd0, S_INIT});
    chk("rst_mid_cmd", {28'd0, sdram_cmd}, {28'd0, C_NOP});
    chk("rst_mid_overrun", {30'd0, ref_overrun, ref_req}, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("no_grant_before_init", {25'd0, state, wr_en}, {25'd0, S_INIT, 1'b0});
    end
    push(S_ARBIT, 3'b000);
    push(S_WRITE, 3'b010);
    flag_init_end = 1'b1;
    step();
    step();
    wr_req = 1'b0;
    push(S_ARBIT, 3'b000);
    flag_wr_end = 1'b1;
    step();
    flag_wr_end = 1'b0;

    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
        step();
        n++;
      end
      chk("scoreboard_drained", exp_q.size(), 32'd0);
    end
    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
